// File: rtl/ct_split.sv
// ct_split: packet demux steering whole packets to one of NO outputs.
// Optional macro CT_SPLIT_DROP_EN: discard packets with a bad destination.
module ct_split #(
    parameter int NO       = 2,
    parameter int WIDTH    = 1,
    parameter int EOP_LOC  = 0,
    parameter int DEST_LOC = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [NO*WIDTH-1:0] o_data,
    output logic [NO-1:0]       o_valid,
    input  logic [NO-1:0]       i_ready
);

    localparam int NOBITS = (NO > 1) ? $clog2(NO) : 1;
    localparam logic [NOBITS:0]   NO_W = (NOBITS+1)'(NO);
    localparam logic [NOBITS-1:0] LAST = NOBITS'(NO - 1);

    localparam logic [1:0] ST_SOP  = 2'd0;
    localparam logic [1:0] ST_BODY = 2'd1;
`ifdef CT_SPLIT_DROP_EN
    localparam logic [1:0] ST_DROP = 2'd2;
`endif

    logic [1:0]                  state_q, state_d;
    logic [NOBITS-1:0]           dest_q, dest_d;
    logic [NO-1:0]               out_valid_q, out_valid_d;
    logic [NO-1:0][WIDTH-1:0]    out_data_q, out_data_d;

    logic [NOBITS-1:0] field;
    logic [NOBITS-1:0] dest;
    logic              sop;
    logic              bad;
    logic              drop;
    logic              sel_v;
    logic              sel_r;
    logic              acc;
    logic              eop;

    // Destination field of the current beat; absent if it does not fit the beat.
    generate
        if (DEST_LOC + NOBITS <= WIDTH) begin : g_field
            assign field = i_data[DEST_LOC +: NOBITS];
        end else begin : g_nofield
            assign field = '0;
        end
    endgenerate

    assign eop = i_data[EOP_LOC];
    assign sop = (state_q == ST_SOP);
    assign bad = ({1'b0, field} >= NO_W);

    // Resolve the beat destination and whether it is being discarded.
    always_comb begin
        dest = dest_q;
        if (sop) begin
            dest = bad ? LAST : field;
        end
`ifdef CT_SPLIT_DROP_EN
        drop = (sop && bad) || (state_q == ST_DROP);
`else
        drop = 1'b0;
`endif
    end

    // Look up occupancy and downstream ready of the selected output.
    always_comb begin
        sel_v = 1'b0;
        sel_r = 1'b0;
        for (int k = 0; k < NO; k++) begin
            if (dest == NOBITS'(k)) begin
                sel_v = out_valid_q[k];
                sel_r = i_ready[k];
            end
        end
    end

    assign o_ready = reset && (drop || !sel_v || sel_r);
    assign acc     = i_valid && o_ready;

    // Packet framing: advance only on accepted beats, lock dest on first beat.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        if (acc) begin
            unique case (state_q)
                ST_SOP: begin
                    if (!eop) begin
                        dest_d = dest;
`ifdef CT_SPLIT_DROP_EN
                        state_d = bad ? ST_DROP : ST_BODY;
`else
                        state_d = ST_BODY;
`endif
                    end
                end
                ST_BODY: begin
                    if (eop) state_d = ST_SOP;
                end
`ifdef CT_SPLIT_DROP_EN
                ST_DROP: begin
                    if (eop) state_d = ST_SOP;
                end
`endif
                default: state_d = ST_SOP;
            endcase
        end
    end

    // Per-output stage: a new beat wins over a drain in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < NO; k++) begin
            if (acc && !drop && dest == NOBITS'(k)) begin
                out_valid_d[k] = 1'b1;
                out_data_d[k]  = i_data;
            end else if (out_valid_q[k] && i_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_SOP;
            dest_q      <= '0;
            out_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output data registers carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign o_data  = out_data_q;
    assign o_valid = out_valid_q;

endmodule

// File: tb/tb_ct_split.sv
// Scoreboard bench for ct_split: NO=4 and NO=3 instances, WIDTH=8.
// Expected beats are queued per output; monitors pop on output handshakes.
module tb_ct_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst4, v4i, rdy4;
    logic [7:0]  d4;
    logic [31:0] od4;
    logic [3:0]  v4, ir4;

    logic        rst3, v3i, rdy3;
    logic [7:0]  d3;
    logic [23:0] od3;
    logic [2:0]  v3, ir3;

    ct_split #(.NO(4), .WIDTH(8), .EOP_LOC(0), .DEST_LOC(1)) u4 (
        .clk(clk), .reset(rst4), .i_data(d4), .i_valid(v4i),
        .o_ready(rdy4), .o_data(od4), .o_valid(v4), .i_ready(ir4)
    );

    ct_split #(.NO(3), .WIDTH(8), .EOP_LOC(0), .DEST_LOC(1)) u3 (
        .clk(clk), .reset(rst3), .i_data(d3), .i_valid(v3i),
        .o_ready(rdy3), .o_data(od3), .o_valid(v3), .i_ready(ir3)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q4 [4][$];
    logic [7:0] q3 [3][$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor for the NO=4 instance.
    always @(negedge clk) begin
        if (rst4 === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (v4[k] === 1'b1 && ir4[k] === 1'b1) begin
                    if (q4[k].size() == 0) begin
                        check($sformatf("u4_unexp_out%0d", k), {24'd0, od4[8*k +: 8]}, 32'hDEAD);
                    end else begin
                        check($sformatf("u4_out%0d", k), {24'd0, od4[8*k +: 8]},
                              {24'd0, q4[k].pop_front()});
                    end
                end
            end
        end
    end

    // Monitor for the NO=3 instance.
    always @(negedge clk) begin
        if (rst3 === 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                if (v3[k] === 1'b1 && ir3[k] === 1'b1) begin
                    if (q3[k].size() == 0) begin
                        check($sformatf("u3_unexp_out%0d", k), {24'd0, od3[8*k +: 8]}, 32'hDEAD);
                    end else begin
                        check($sformatf("u3_out%0d", k), {24'd0, od3[8*k +: 8]},
                              {24'd0, q3[k].pop_front()});
                    end
                end
            end
        end
    end

    task automatic send4(input logic [7:0] b);
        int w;
        w   = 0;
        v4i = 1'b1;
        d4  = b;
        @(negedge clk);
        while (!rdy4 && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("u4_accept", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic [7:0] b);
        int w;
        w   = 0;
        v3i = 1'b1;
        d3  = b;
        @(negedge clk);
        while (!rdy3 && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("u3_accept", {31'd0, rdy3}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    int c0;

    initial begin
        rst4 = 1'b0; v4i = 1'b0; d4 = 8'h00; ir4 = 4'hF;
        rst3 = 1'b0; v3i = 1'b0; d3 = 8'h00; ir3 = 3'h7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid4", {28'd0, v4}, 32'd0);
        check("rst_ready4", {31'd0, rdy4}, 32'd0);
        check("rst_valid3", {29'd0, v3}, 32'd0);
        check("rst_ready3", {31'd0, rdy3}, 32'd0);
        rst4 = 1'b1;
        rst3 = 1'b1;
        #1;
        check("idle_ready4", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        #1;

        // 3-beat packet to out2
        q4[2].push_back(8'h04);
        q4[2].push_back(8'h00);
        q4[2].push_back(8'h01);
        c0 = cyc;
        send4(8'h04);
        check("lat_valid", {28'd0, v4}, 32'h4);
        check("lat_data", {24'd0, od4[23:16]}, 32'h04);
        send4(8'h00);
        send4(8'h01);
        check("p1_rate", cyc - c0, 3);
        v4i = 1'b0;
        @(posedge clk);
        #1;

        // stall out1, then a packet to out3
        ir4[1] = 1'b0;
        q4[1].push_back(8'h02);
        q4[1].push_back(8'h01);
        q4[3].push_back(8'h07);
        send4(8'h02);
        d4 = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, rdy4}, 32'd0);
            check("stall_data", {24'd0, od4[15:8]}, 32'h02);
            check("stall_valid", {28'd0, v4}, 32'h2);
        end
        @(posedge clk);
        #1;
        ir4[1] = 1'b1;
        send4(8'h01);
        send4(8'h07);
        v4i = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back single-beat packets
        q4[0].push_back(8'h01);
        q4[1].push_back(8'h03);
        q4[2].push_back(8'h05);
        q4[3].push_back(8'h07);
        c0 = cyc;
        send4(8'h01);
        send4(8'h03);
        send4(8'h05);
        send4(8'h07);
        check("b2b_rate", cyc - c0, 4);
        v4i = 1'b0;
        @(posedge clk);
        #1;

        // bad destination on NO=3
`ifndef CT_SPLIT_DROP_EN
        q3[2].push_back(8'h06);
        q3[2].push_back(8'h00);
        q3[2].push_back(8'h01);
`endif
        c0 = cyc;
        send3(8'h06);
`ifdef CT_SPLIT_DROP_EN
        check("drop_v0", {29'd0, v3}, 32'd0);
`else
        check("clamp_v0", {29'd0, v3}, 32'h4);
`endif
        send3(8'h00);
        send3(8'h01);
        check("bad_rate", cyc - c0, 3);
        v3i = 1'b0;
        @(posedge clk);
        #1;
        check("bad_after", {29'd0, v3}, 32'd0);

        // mid-packet reset on out1
        q4[1].push_back(8'h02);
        send4(8'h02);
        send4(8'h00);
        ir4[1] = 1'b0;
        d4 = 8'h00;
        rst4 = 1'b0;
        #1;
        check("mrst_ready_a", {31'd0, rdy4}, 32'd0);
        @(posedge clk);
        #1;
        check("mrst_valid", {28'd0, v4}, 32'd0);
        check("mrst_ready_b", {31'd0, rdy4}, 32'd0);
        rst4 = 1'b1;
        ir4 = 4'hF;
        q4[1].push_back(8'h02);
        q4[1].push_back(8'h01);
        send4(8'h02);
        check("mrst_sop", {28'd0, v4}, 32'h2);
        send4(8'h01);
        v4i = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("u4_left%0d", k), q4[k].size(), 0);
        for (int k = 0; k < 3; k++)
            check($sformatf("u3_left%0d", k), q3[k].size(), 0);
        check("end_valid4", {28'd0, v4}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ct_split.md
# ct_split

Packet demultiplexer sitting directly downstream of the merge stage: accepts one ready/valid packet stream and steers each whole packet to one of NO outputs. The destination is taken from a field in the first beat and held until the EOP beat is accepted, so packets are never interleaved on an output. Each output has a one-beat registered stage, giving full throughput per output and isolating downstream ready from upstream timing.

## Interface
- NO, 2: number of outputs; must be ≥ 2.
- WIDTH, 1: beat width in bits.
- EOP_LOC, 0: bit index of the end-of-packet flag within a beat.
- DEST_LOC, 1: LSB index of the destination field in the first beat; field is NOBITS = clog2(NO) wide and must fit in WIDTH.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- i_data  in  WIDTH  input beat.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted this cycle when i_valid && o_ready.
- o_data  out  NO*WIDTH  output beats; output k at [WIDTH*k +: WIDTH].
- o_valid  out  NO  per-output valid.
- i_ready  in  NO  per-output downstream ready.

## Operation
- Per output k: register out_data[k] and valid bit out_valid[k], driven onto o_data and o_valid.
- Beat destination: in SOP state, dest = i_data[DEST_LOC +: NOBITS]. In BODY state, dest = the locked register.
- Bad destination: dest ≥ NO (possible only when NO is not a power of 2). Handling is set by the configuration macro.
- o_ready = !out_valid[dest] || i_ready[dest] for a good destination. In DROP state, o_ready = 1.
- Accepted beat to good dest: out_data[dest] <= i_data and out_valid[dest] <= 1.
- Output k drained (out_valid[k] && i_ready[k]) with no new beat to k: out_valid[k] <= 0.
- Outputs are independent: a stalled output does not block draining of the others.
- State machine, advanced only on an accepted beat:
  - SOP:
    - eop=0 → BODY, and dest is locked.
    - eop=1 → stays SOP (single-beat packet).
    - Bad dest with the drop feature enabled: eop=0 → DROP; eop=1 → stays SOP, beat discarded.
  - BODY: eop=1 → SOP; otherwise stays BODY.
  - DROP: every beat is discarded; eop=1 → SOP.
- The locked dest changes only on the SOP→BODY or SOP→DROP transition.
- The destination field of non-first beats is ignored.

## Timing
- Reset (reset=0 at a clock edge) forces the following, regardless of state:
  - State is SOP.
  - Locked dest is 0.
  - All out_valid are 0, so o_valid = 0.
  - o_ready = 0 while reset is asserted.
  - out_data is don't-care.
- Reset mid-packet: the partial packet is abandoned, and the first beat after reset release is treated as SOP.
- Latency: a beat accepted at edge N appears on o_valid/o_data after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle when the target output has i_ready held at 1.
- Simultaneous drain and fill on the same output in one cycle: the new beat wins and out_valid stays 1, with no bubble.
- o_ready depends combinationally on i_data (SOP state) and on i_ready[dest]. It must not depend on i_valid.
- Downstream stall: o_valid[k] and o_data[k] hold stable until i_ready[k]=1.

## Configuration
- CT_SPLIT_DROP_EN defined:
  - Packets with a bad destination are consumed at 1 beat/cycle (o_ready=1) and discarded.
  - No o_valid is raised for them.
  - The DROP state exists.
- CT_SPLIT_DROP_EN undefined:
  - A bad destination is clamped to NO-1 and the packet is delivered there normally.
  - There is no DROP state.

## Test plan
- NO=4, WIDTH=8, EOP_LOC=0, DEST_LOC=1:
  - Stimulus: 3-beat packet 0x04, 0x00, 0x01, all i_ready=1.
  - Required: out2 emits 0x04, 0x00, 0x01 on consecutive cycles, starting 1 cycle after the first accept; o_valid[0,1,3] stay 0.
- Same config:
  - Stimulus: packet to out1 with i_ready[1]=0 for 5 cycles, then a packet to out3.
  - Required: o_ready=0 after the first beat fills out1; out1 holds 0x02 stable; the out3 packet is not accepted until out1's packet completes.
- Same config, back-to-back single-beat packets 0x01, 0x03, 0x05, 0x07:
  - Required: outputs 0, 1, 2, 3 each receive exactly one beat, with one accept per cycle.
- NO=3, WIDTH=8, with a first beat of dest field 3 (0x06), then 0x00, 0x01:
  - With CT_SPLIT_DROP_EN: 3 beats accepted in 3 cycles, all o_valid stay 0.
  - Without CT_SPLIT_DROP_EN: the packet appears on out2.
- Mid-packet reset:
  - Stimulus: reset=0 for 1 cycle after beat 2 of a 4-beat packet to out1, with i_ready[1]=0.
  - Required: o_valid=0 and o_ready=0 during reset. The next beat 0x02 after release is treated as SOP and routed to out1 as a new packet.
